// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that funnels register-file writebacks from NumReq requesters
// into a single registered output slot, discarding writes to x0 and counting them.
module regfile_wb_arbiter #(
    parameter int NumReq       = 3,
    parameter int RegWidth     = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic [NumReq-1:0]                            req_valid,
    input  logic [NumReq-1:0][RegWidth+RegAddrWidth-1:0] req_data,
    output logic [NumReq-1:0]                            req_ready,
    output logic                                         wb_valid,
    output logic [RegWidth+RegAddrWidth-1:0]             wb_data,
    input  logic                                         wb_ready,
    output logic [7:0]                                   drop_cnt
);

    localparam int PtrW = $clog2(NumReq);

    // Transport layout: value in the upper bits, register address in the lower bits.
    typedef struct packed {
        logic [RegWidth-1:0]     value;
        logic [RegAddrWidth-1:0] addr;
    } reg_transport_t;

    logic [PtrW-1:0] ptr_q, ptr_d;
    reg_transport_t  wb_data_q, wb_data_d;
    logic            wb_valid_q, wb_valid_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic            slot_free;
    logic            grant_any;
    logic [PtrW-1:0] grant_idx;
    reg_transport_t  grant_data;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        int idx;
        idx       = 0;
        slot_free = !wb_valid_q || wb_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PtrW'(idx);
            end
        end
        // Reset and a busy slot both suppress every grant.
        if (!nrst || !slot_free) grant_any = 1'b0;
        req_ready  = grant_any ? (NumReq'(1) << grant_idx) : '0;
        grant_data = reg_transport_t'(req_data[grant_idx]);
    end

    always_comb begin
        ptr_d      = ptr_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = wb_valid_q;
        drop_cnt_d = drop_cnt_q;
        if (wb_valid_q && wb_ready) wb_valid_d = 1'b0;
        if (grant_any) begin
            ptr_d = (grant_idx == PtrW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
            if (grant_data.addr != '0) begin
                wb_data_d  = grant_data;
                wb_valid_d = 1'b1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q      <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            ptr_q      <= ptr_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table for arbitration
// and backpressure, plus hand sequences for x0 drops, saturation and async reset.
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int RW = 32;
    localparam int AW = 5;
    localparam int TW = RW + AW;

    logic                   clk;
    logic                   nrst;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][TW-1:0]  req_data;
    logic [NR-1:0]          req_ready;
    logic                   wb_valid;
    logic [TW-1:0]          wb_data;
    logic                   wb_ready;
    logic [7:0]             drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.NumReq(NR), .RegWidth(RW), .RegAddrWidth(AW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] v;
        logic [4:0] a0, a1, a2;
        logic       rdy;
        logic [2:0] exp_ready;
        logic       exp_valid;
        int         exp_src;
        logic [4:0] exp_addr;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [TW-1:0] mk(int src, logic [4:0] addr);
        logic [31:0] val;
        val = 32'hC0DE_0000 + 32'(src * 256) + 32'(addr);
        return {val, addr};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [2:0] v, logic [TW-1:0] d0, logic [TW-1:0] d1,
                         logic [TW-1:0] d2, logic rdy);
        req_valid   = v;
        req_data[0] = d0;
        req_data[1] = d1;
        req_data[2] = d2;
        wb_ready    = rdy;
    endtask

    // Checks req_ready mid-cycle, then the registered outputs just after the edge.
    task automatic cyc(string name, logic [2:0] exp_ready, logic exp_valid,
                       logic [TW-1:0] exp_data, logic chk_data);
        @(negedge clk);
        check({name, " req_ready"}, 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        check({name, " wb_valid"}, 64'(wb_valid), 64'(exp_valid));
        if (chk_data) check({name, " wb_data"}, 64'(wb_data), 64'(exp_data));
    endtask

    initial begin
        tbl[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 3'b001, 1'b1, 0, 5'd1};
        tbl[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 3'b010, 1'b1, 1, 5'd2};
        tbl[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 3'b100, 1'b1, 2, 5'd3};
        tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 3'b001, 1'b1, 0, 5'd1};
        tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 3'b010, 1'b1, 1, 5'd2};
        tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 3'b100, 1'b1, 2, 5'd3};
        tbl[6]  = '{3'b000, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000, 1'b0, 0, 5'd0};
        tbl[7]  = '{3'b001, 5'd1, 5'd2, 5'd3, 1'b1, 3'b001, 1'b1, 0, 5'd1};
        tbl[8]  = '{3'b101, 5'd1, 5'd2, 5'd3, 1'b1, 3'b100, 1'b1, 2, 5'd3};
        tbl[9]  = '{3'b101, 5'd1, 5'd2, 5'd3, 1'b1, 3'b001, 1'b1, 0, 5'd1};
        tbl[10] = '{3'b000, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000, 1'b0, 0, 5'd0};
        tbl[11] = '{3'b010, 5'd1, 5'd2, 5'd3, 1'b0, 3'b010, 1'b1, 1, 5'd2};
        tbl[12] = '{3'b011, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000, 1'b1, 1, 5'd2};
        tbl[13] = '{3'b011, 5'd1, 5'd2, 5'd3, 1'b1, 3'b001, 1'b1, 0, 5'd1};

        // Reset held with every requester asking.
        nrst = 1'b0;
        drive(3'b111, mk(0, 5'd1), mk(1, 5'd2), mk(2, 5'd3), 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset wb_valid", 64'(wb_valid), 64'd0);
        check("reset wb_data", 64'(wb_data), 64'd0);
        check("reset drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, mk(0, tbl[i].a0), mk(1, tbl[i].a1), mk(2, tbl[i].a2), tbl[i].rdy);
            cyc($sformatf("row%0d", i), tbl[i].exp_ready, tbl[i].exp_valid,
                mk(tbl[i].exp_src, tbl[i].exp_addr), tbl[i].exp_valid);
        end

        // Backpressure: park {DEADBEEF,5}, stall, then release.
        drive(3'b001, {32'hDEAD_BEEF, 5'd5}, mk(1, 5'd2), mk(2, 5'd3), 1'b1);
        cyc("bp load", 3'b001, 1'b1, {32'hDEAD_BEEF, 5'd5}, 1'b1);
        drive(3'b010, mk(0, 5'd1), {32'h1111_2222, 5'd7}, mk(2, 5'd3), 1'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("bp stall%0d", i), 3'b000, 1'b1, {32'hDEAD_BEEF, 5'd5}, 1'b1);
        wb_ready = 1'b1;
        cyc("bp release", 3'b010, 1'b1, {32'h1111_2222, 5'd7}, 1'b1);

        // x0 drop from requester 2 while the output drains.
        drive(3'b100, mk(0, 5'd1), mk(1, 5'd2), {32'h0000_1234, 5'd0}, 1'b1);
        cyc("x0 drop", 3'b100, 1'b0, '0, 1'b0);
        check("x0 drop_cnt", 64'(drop_cnt), 64'd1);
        drive(3'b111, mk(0, 5'd1), mk(1, 5'd2), mk(2, 5'd3), 1'b1);
        cyc("ptr after drop", 3'b001, 1'b1, mk(0, 5'd1), 1'b1);

        // Saturation of the drop counter.
        drive(3'b001, {32'h0000_1234, 5'd0}, mk(1, 5'd2), mk(2, 5'd3), 1'b1);
        repeat (253) @(posedge clk);
        #1;
        check("drop_cnt 254", 64'(drop_cnt), 64'd254);
        check("drops keep wb idle", 64'(wb_valid), 64'd0);
        repeat (47) @(posedge clk);
        #1;
        check("drop_cnt sat", 64'(drop_cnt), 64'd255);

        // Async reset in the middle of a stall.
        drive(3'b010, mk(0, 5'd1), mk(1, 5'd9), mk(2, 5'd3), 1'b1);
        cyc("pre-reset load", 3'b010, 1'b1, mk(1, 5'd9), 1'b1);
        drive(3'b111, mk(0, 5'd1), mk(1, 5'd2), mk(2, 5'd3), 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        check("async wb_valid", 64'(wb_valid), 64'd0);
        check("async wb_data", 64'(wb_data), 64'd0);
        check("async drop_cnt", 64'(drop_cnt), 64'd0);
        check("async req_ready", 64'(req_ready), 64'd0);
        #2;
        nrst = 1'b1;
        drive(3'b000, mk(0, 5'd1), mk(1, 5'd2), mk(2, 5'd3), 1'b1);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("post-reset idle%0d", i), 3'b000, 1'b0, '0, 1'b0);
        drive(3'b111, mk(0, 5'd1), mk(1, 5'd2), mk(2, 5'd3), 1'b1);
        cyc("post-reset first grant", 3'b001, 1'b1, mk(0, 5'd1), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 3, meaning the number of writeback requesters (2..8).
REQ-002 The block SHALL have parameter RegWidth, default 32, meaning the register value width in bits.
REQ-003 The block SHALL have parameter RegAddrWidth, default 5, meaning the register address width in bits.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port nrst  input  1  meaning the reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid  input  NumReq  meaning requester i offers a write on bit i.
REQ-007 The block SHALL have port req_data  input  NumReq x reg_transport_t  meaning the offered {value, addr} per requester.
REQ-008 The block SHALL have port req_ready  output  NumReq  meaning requester i's offer is accepted this cycle.
REQ-009 The block SHALL have port wb_valid  output  1  meaning the output register holds a write for the register file.
REQ-010 The block SHALL have port wb_data  output  reg_transport_t  meaning the held {value, addr}.
REQ-011 The block SHALL have port wb_ready  input  1  meaning the register file consumes wb_data this cycle.
REQ-012 The block SHALL have port drop_cnt  output  8  meaning the saturating count of accepted writes to x0.

Function
REQ-013 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high at a rising clk edge; a transfer on the output SHALL occur when wb_valid and wb_ready are both high.
REQ-014 The output register SHALL be able to load when wb_valid is low or the output transfers in the same cycle ("slot free").
REQ-015 When the slot is free, at most one req_ready bit SHALL be high: the first i with req_valid[i] high, searching from ptr upward modulo NumReq.
REQ-016 When the slot is not free, all req_ready bits SHALL be low.
REQ-017 req_ready SHALL be combinational from req_valid, ptr, wb_valid and wb_ready; req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-018 On a transfer from requester i, ptr SHALL become (i+1) mod NumReq on the next edge; otherwise ptr SHALL hold.
REQ-019 On a transfer with addr != 0, wb_data SHALL load req_data[i] and wb_valid SHALL be 1 on the next edge (one-cycle latency).
REQ-020 On a transfer with addr == 0, the write SHALL be discarded: wb_data unchanged, wb_valid becomes 0 if the output transferred that cycle and otherwise holds, drop_cnt increments, saturating at 255.
REQ-021 With no requester transfer and an output transfer, wb_valid SHALL become 0; wb_data is don't-care while wb_valid is 0.
REQ-022 While wb_valid is high and wb_ready low, wb_data SHALL be held stable.
REQ-023 The block SHALL sustain one write per cycle when wb_ready is held high.
REQ-024 Requesters whose req_valid drops before acceptance SHALL not be tracked; the arbiter keeps no per-requester state beyond ptr.

Reset
REQ-025 While nrst is low, wb_valid SHALL be 0, wb_data 0, ptr 0, drop_cnt 0, and req_ready all 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard any held write; the first grant after release SHALL search from requester 0.

Verification
REQ-027 Reset: nrst low with all req_valid high -> req_ready=000, wb_valid=0, drop_cnt=0; release -> first grant to req 0.
REQ-028 Round-robin: req_valid=111 constant, wb_ready=1, addrs 1/2/3 -> wb_data.addr sequence 1,2,3,1,2,3 one per cycle from cycle 1.
REQ-029 Backpressure: wb_ready=0 with a held write of {0xDEADBEEF,5} and req_valid=010 -> req_ready=000, wb_data stable; raise wb_ready -> req 1 granted same cycle, its write appears next cycle.
REQ-030 x0 drop: req 2 offers {0x1234,0} -> accepted, wb_valid stays 0, drop_cnt 0->1, ptr becomes 0; 300 such drops -> drop_cnt=255.
REQ-031 Pointer fairness: req_valid=101 from ptr=1 -> req 2 granted first, then req 0.
REQ-032 Async reset mid-stall: wb_valid=1, wb_ready=0, nrst pulsed low between edges -> wb_valid=0 immediately, no write later emerges.
